// File: rtl/vblank_scheduler_pkg.sv
// Shared definitions for the vertical-blank update scheduler.
//   VVIDEO_ON : first line of vertical blanking (blank-start line)
//   state_t   : scheduler FSM state encoding
package vblank_scheduler_pkg;

   localparam logic [9:0] VVIDEO_ON = 10'd480;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_GRANT = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

endpackage

// File: rtl/vblank_scheduler_prio_enc.sv
// prio_enc: lowest-set-bit priority encoder (index 0 highest priority).
// Ports:
//   vec    in  NREQ  request vector
//   onehot out NREQ  one-hot lowest set bit of vec (zero when vec == 0)
//   valid  out 1     vec has at least one bit set
module prio_enc #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] vec,
   output logic [NREQ-1:0] onehot,
   output logic            valid
);

   // Two's-complement trick isolates the lowest set bit.
   assign onehot = vec & (~vec + NREQ'(1));
   assign valid  = |vec;

endmodule

// File: rtl/vblank_scheduler.sv
// vblank_scheduler: hands out one update slot per requester during vertical
// blanking, fixed priority (index 0 highest), one grant at a time.
// Ports:
//   i_pixel_clock in  1     clock
//   i_reset       in  1     asynchronous active-high reset
//   i_hpos/i_vpos in  10    raster position from the sync generator
//   i_req         in  NREQ  level requests, latched once at blank start
//   i_done        in  NREQ  pulse ending the granted slot (other bits ignored)
//   o_grant       out NREQ  registered one-hot-or-zero grant
//   o_frame_tick  out 1     pulse at blank start
//   o_busy        out 1     high in SCAN or GRANT
//   o_timeout     out 1     pulse when the watchdog revokes a grant
//   o_overrun     out 1     sticky: blanking ended with work unfinished
// Build option: define VBLANK_SCHED_WATCHDOG_EN to limit each grant to
// WDOG_CYCLES cycles; without it o_timeout is tied low.
//
// state | meaning
// IDLE  | waiting for blank start
// SCAN  | picking the next pending requester (grant low this cycle)
// GRANT | one requester owns the slot
// WAIT  | frame's work done, waiting for active start
module vblank_scheduler
   import vblank_scheduler_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int WDOG_CYCLES = 8000
) (
   input  logic            i_pixel_clock,
   input  logic            i_reset,
   input  logic [9:0]      i_hpos,
   input  logic [9:0]      i_vpos,
   input  logic [NREQ-1:0] i_req,
   input  logic [NREQ-1:0] i_done,
   output logic [NREQ-1:0] o_grant,
   output logic            o_frame_tick,
   output logic            o_busy,
   output logic            o_timeout,
   output logic            o_overrun
);

   if (WDOG_CYCLES < 1) begin : g_bad_wdog
      $error("WDOG_CYCLES must be at least 1");
   end

   state_t            state_q, state_d;
   logic [NREQ-1:0]   pending_q, pending_d;
   logic [NREQ-1:0]   grant_d;
   logic              tick_d, busy_d, overrun_d;
   logic [NREQ-1:0]   pick;
   logic              pick_valid;
   logic              blank_start, active_start, done_hit;

   assign blank_start  = (i_vpos == VVIDEO_ON) && (i_hpos == 10'd0);
   assign active_start = (i_vpos == 10'd0) && (i_hpos == 10'd0);
   assign done_hit     = |(i_done & o_grant);

   prio_enc #(.NREQ(NREQ)) u_prio_enc (
      .vec    (pending_q),
      .onehot (pick),
      .valid  (pick_valid)
   );

`ifdef VBLANK_SCHED_WATCHDOG_EN
   localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              timeout_d;
   logic              wdog_expired;

   assign wdog_expired = (wdog_q == '0);
`endif

   // State register and registered outputs.
   always_ff @(posedge i_pixel_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         o_grant      <= '0;
         o_frame_tick <= 1'b0;
         o_busy       <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         o_grant      <= grant_d;
         o_frame_tick <= tick_d;
         o_busy       <= busy_d;
         o_overrun    <= overrun_d;
      end
   end

`ifdef VBLANK_SCHED_WATCHDOG_EN
   always_ff @(posedge i_pixel_clock or posedge i_reset) begin
      if (i_reset) begin
         wdog_q    <= '0;
         o_timeout <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         o_timeout <= timeout_d;
      end
   end
`else
   assign o_timeout = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (blank_start) state_d = ST_SCAN;
         ST_SCAN: begin
            if (active_start)    state_d = ST_IDLE;
            else if (pick_valid) state_d = ST_GRANT;
            else                 state_d = ST_WAIT;
         end
         ST_GRANT: begin
            if (active_start)  state_d = ST_IDLE;
            else if (done_hit) state_d = ST_SCAN;
`ifdef VBLANK_SCHED_WATCHDOG_EN
            else if (wdog_expired) state_d = ST_SCAN;
`endif
         end
         ST_WAIT:  if (active_start) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / datapath logic; results are registered above.
   always_comb begin
      pending_d = pending_q;
      grant_d   = o_grant;
      tick_d    = 1'b0;
      overrun_d = o_overrun;
`ifdef VBLANK_SCHED_WATCHDOG_EN
      wdog_d    = wdog_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (blank_start) begin
               pending_d = i_req;
               tick_d    = 1'b1;
            end
         end
         ST_SCAN: begin
            if (active_start) begin
               overrun_d = o_overrun | (|pending_q);
               pending_d = '0;
               grant_d   = '0;
            end else if (pick_valid) begin
               grant_d   = pick;
               pending_d = pending_q & ~pick;
`ifdef VBLANK_SCHED_WATCHDOG_EN
               wdog_d    = WDOG_LOAD;
`endif
            end else begin
               grant_d = '0;
            end
         end
         ST_GRANT: begin
            // A grant is always held in GRANT, so active start here is an overrun.
            if (active_start) begin
               overrun_d = 1'b1;
               pending_d = '0;
               grant_d   = '0;
            end else if (done_hit) begin
               grant_d = '0;
            end
`ifdef VBLANK_SCHED_WATCHDOG_EN
            else if (wdog_expired) begin
               grant_d   = '0;
               timeout_d = 1'b1;
            end else begin
               wdog_d = wdog_q - WDOG_W'(1);
            end
`endif
         end
         default: grant_d = '0;
      endcase
      busy_d = (state_d == ST_SCAN) || (state_d == ST_GRANT);
   end

endmodule

// File: tb/tb_vblank_scheduler.sv
module tb_vblank_scheduler;

   localparam int NREQ = 4;
   localparam int WDOG = 16;
`ifdef VBLANK_SCHED_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [9:0]      hpos = 10'd5;
   logic [9:0]      vpos = 10'd100;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] done = '0;
   logic [NREQ-1:0] grant;
   logic            frame_tick, busy, timeout, overrun;

   vblank_scheduler #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
      .i_pixel_clock (clk),
      .i_reset       (rst),
      .i_hpos        (hpos),
      .i_vpos        (vpos),
      .i_req         (req),
      .i_done        (done),
      .o_grant       (grant),
      .o_frame_tick  (frame_tick),
      .o_busy        (busy),
      .o_timeout     (timeout),
      .o_overrun     (overrun)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: tracks the frame in terms of who owns the slot and
   // who is still owed one, rather than an explicit state machine.
   bit              m_open;     // blank-start seen, frame not yet released
   bit              m_gap;      // next cycle chooses the next owner
   int              m_owner;    // current owner index, -1 for none
   int              m_budget;   // cycles of ownership left before revocation
   logic [NREQ-1:0] m_left;     // requesters still owed a slot this frame
   logic [NREQ-1:0] m_grant;
   logic            m_tick, m_busy, m_timeout, m_overrun;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_open = 0; m_gap = 0; m_owner = -1; m_budget = 0; m_left = '0;
         m_grant = '0; m_tick = 0; m_busy = 0; m_timeout = 0; m_overrun = 0;
      end else begin
         bit blank_ev, active_ev;
         blank_ev  = (vpos == 10'd480) && (hpos == 10'd0);
         active_ev = (vpos == 10'd0) && (hpos == 10'd0);
         m_tick = 0;
         m_timeout = 0;
         if (!m_open) begin
            if (blank_ev) begin
               m_open = 1; m_gap = 1; m_left = req; m_tick = 1;
            end
         end else if (m_gap) begin
            m_gap = 0;
            if (active_ev) begin
               if (m_left != 0) m_overrun = 1;
               m_open = 0; m_left = '0;
            end else if (m_left != 0) begin
               for (int i = NREQ - 1; i >= 0; i--) if (m_left[i]) m_owner = i;
               m_left[m_owner] = 1'b0;
               m_budget = WDOG - 1;
            end
         end else if (m_owner >= 0) begin
            if (active_ev) begin
               m_overrun = 1; m_owner = -1; m_open = 0; m_left = '0;
            end else if (done[m_owner]) begin
               m_owner = -1; m_gap = 1;
            end else if (WD_ON && m_budget == 0) begin
               m_owner = -1; m_gap = 1; m_timeout = 1;
            end else begin
               m_budget = m_budget - 1;
            end
         end else if (active_ev) begin
            m_open = 0;
         end
         m_grant = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
         m_busy  = m_gap || (m_owner >= 0);
      end
   end

   // Literal expectations posted by the stimulus, checked by the compare process.
   string       lit_name = "";
   logic [7:0]  lit_val = '0;
   int          lit_id = 0;
   int          lit_seen = 0;
   logic [7:0]  dut_vec;
   assign dut_vec = {grant, frame_tick, busy, timeout, overrun};

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("grant",      {4'b0, grant},        {4'b0, m_grant});
         chk("frame_tick", {7'b0, frame_tick},   {7'b0, m_tick});
         chk("busy",       {7'b0, busy},         {7'b0, m_busy});
         chk("timeout",    {7'b0, timeout},      {7'b0, m_timeout});
         chk("overrun",    {7'b0, overrun},      {7'b0, m_overrun});
      end
      if (lit_id != lit_seen) begin
         lit_seen = lit_id;
         chk(lit_name, dut_vec, lit_val);
      end
   end

   // {grant[3:0], frame_tick, busy, timeout, overrun}
   task automatic expect_lit(input string nm, input logic [7:0] v);
      lit_name = nm;
      lit_val  = v;
      lit_id++;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic blank_ev();
      hpos = 10'd0; vpos = 10'd480;
      cyc(1);
      hpos = 10'd5; vpos = 10'd100;
   endtask

   task automatic active_ev();
      hpos = 10'd0; vpos = 10'd0;
      cyc(1);
      hpos = 10'd5; vpos = 10'd100;
   endtask

   task automatic pulse_done(input logic [NREQ-1:0] v);
      done = v;
      cyc(1);
      done = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before %0t", $time);
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      cyc(2);
      expect_lit("reset_state", 8'b0000_0000);
      cyc(1);
      rst = 1'b0;
      cyc(1);

      // Two requesters served in priority order, then WAIT.
      req = 4'b1010;
      blank_ev();
      expect_lit("tick_after_blank", 8'b0000_1100);
      cyc(1);
      expect_lit("first_grant", 8'b0010_0100);
      cyc(3);
      pulse_done(4'b0010);
      expect_lit("scan_gap", 8'b0000_0100);
      cyc(1);
      expect_lit("second_grant", 8'b1000_0100);
      pulse_done(4'b1000);
      expect_lit("scan_gap2", 8'b0000_0100);
      cyc(1);
      expect_lit("wait_state", 8'b0000_0000);
      cyc(1);
      blank_ev();
      expect_lit("blank_in_wait_ignored", 8'b0000_0000);
      cyc(1);
      active_ev();
      cyc(1);

      // Empty frame: busy for the single SCAN cycle only.
      req = 4'b0000;
      blank_ev();
      expect_lit("empty_tick", 8'b0000_1100);
      cyc(1);
      expect_lit("empty_wait", 8'b0000_0000);
      cyc(2);
      active_ev();
      cyc(1);

      // Foreign done ignored; late requests not served; done on expiry cycle.
      req = 4'b0101;
      blank_ev();
      req = 4'b1111;
      cyc(1);
      expect_lit("grant0", 8'b0001_0100);
      pulse_done(4'b0100);
      expect_lit("foreign_done_ignored", 8'b0001_0100);
      blank_ev();
      expect_lit("blank_in_grant_ignored", 8'b0001_0100);
      pulse_done(4'b0001);
      cyc(1);
      expect_lit("grant2", 8'b0100_0100);
      cyc(WDOG - 1);
      pulse_done(4'b0100);
      expect_lit("done_at_expiry", 8'b0000_0100);
      cyc(1);
      expect_lit("late_req_ignored", 8'b0000_0000);
      active_ev();
      req = 4'b0000;
      cyc(1);

`ifdef VBLANK_SCHED_WATCHDOG_EN
      req = 4'b0011;
      blank_ev();
      cyc(1);
      cyc(WDOG - 1);
      expect_lit("wd_hold", 8'b0001_0100);
      cyc(1);
      expect_lit("wd_timeout", 8'b0000_0110);
      cyc(1);
      expect_lit("wd_next_grant", 8'b0010_0100);
      pulse_done(4'b0010);
      cyc(1);
`else
      req = 4'b0001;
      blank_ev();
      cyc(1);
      cyc(40);
      expect_lit("no_watchdog_hold", 8'b0001_0100);
      pulse_done(4'b0001);
      cyc(1);
`endif
      active_ev();
      req = 4'b0000;
      cyc(1);

      // Overrun on active start during a grant; sticky until reset.
      req = 4'b0001;
      blank_ev();
      cyc(4);
      active_ev();
      expect_lit("overrun_set", 8'b0000_0001);
      req = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         blank_ev();
         cyc(1);
         active_ev();
         cyc(1);
      end
      expect_lit("overrun_sticky", 8'b0000_0001);
      rst = 1'b1;
      expect_lit("overrun_cleared", 8'b0000_0000);
      cyc(1);
      rst = 1'b0;
      cyc(1);

      // Reset mid-grant drops the grant at once, then a fresh frame.
      req = 4'b0010;
      blank_ev();
      cyc(3);
      rst = 1'b1;
      expect_lit("rst_mid_grant", 8'b0000_0000);
      cyc(1);
      rst = 1'b0;
      cyc(2);
      expect_lit("post_rst_idle", 8'b0000_0000);
      req = 4'b0100;
      blank_ev();
      expect_lit("fresh_tick", 8'b0000_1100);
      cyc(1);
      expect_lit("fresh_grant", 8'b0100_0100);
      pulse_done(4'b0100);
      cyc(1);
      active_ev();
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
